// File: rtl/dmem_port_arbiter.sv
// Arbiter sharing one synchronous dmem port between the processor (P) and a
// debug/program-loader master (D).
//
// Ports:
//   clock, reset            single clock, asynchronous active-high reset
//   p_req/p_wren/p_address/p_data  processor request (held until p_gnt)
//   p_gnt, p_rvalid, p_q    processor grant and read return
//   d_req/d_wren/d_address/d_data  debug request (held until d_gnt)
//   d_lock                  debug asks for exclusive ownership of dmem
//   d_gnt, d_rvalid, d_q    debug grant and read return
//   locked                  debug currently owns dmem exclusively
//   address_dmem/data/wren  to dmem; q_dmem from dmem (READ_LATENCY cycles)
module dmem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p_req,
  input  logic                  p_wren,
  input  logic [ADDR_WIDTH-1:0] p_address,
  input  logic [DATA_WIDTH-1:0] p_data,
  output logic                  p_gnt,
  output logic                  p_rvalid,
  output logic [DATA_WIDTH-1:0] p_q,
  input  logic                  d_req,
  input  logic                  d_wren,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_data,
  input  logic                  d_lock,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_q,
  output logic                  locked,
  output logic [ADDR_WIDTH-1:0] address_dmem,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  wren,
  input  logic [DATA_WIDTH-1:0] q_dmem
);

  typedef enum logic [0:0] {StOpen, StLocked} lock_state_e;

  // Stages below the tail; a P read sitting there has not returned yet.
  localparam logic [READ_LATENCY-1:0] NonTailMask = {READ_LATENCY{1'b1}} >> 1;

  lock_state_e             lock_state_q, lock_state_d;
  logic                    last_winner_d_q;  // 1: D won the most recent grant
  logic [READ_LATENCY-1:0] tag_valid_q, tag_valid_d;
  logic [READ_LATENCY-1:0] tag_owner_q, tag_owner_d;  // 1: read belongs to D
  logic [DATA_WIDTH-1:0]   p_q_hold_q, d_q_hold_q;
  logic                    grant_p, grant_d;
  logic                    read_push;
  logic                    p_read_pending;
  logic                    tail_valid, tail_owner;

  // Arbitration: lock shuts P out, otherwise round-robin on conflict.
  always_comb begin
    grant_p = 1'b0;
    grant_d = 1'b0;
    if (lock_state_q == StLocked) begin
      grant_d = d_req;
    end else if (p_req && d_req) begin
      grant_p = last_winner_d_q;
      grant_d = ~last_winner_d_q;
    end else begin
      grant_p = p_req;
      grant_d = d_req;
    end
  end

  assign p_gnt  = grant_p;
  assign d_gnt  = grant_d;
  assign locked = (lock_state_q == StLocked);

  always_comb begin
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    if (grant_p) begin
      address_dmem = p_address;
      data         = p_data;
      wren         = p_wren;
    end else if (grant_d) begin
      address_dmem = d_address;
      data         = d_data;
      wren         = d_wren;
    end
  end

  assign read_push = (grant_p & ~p_wren) | (grant_d & ~d_wren);

  // A P read is in flight if granted now or still short of the tail.
  assign p_read_pending = (grant_p & ~p_wren) |
                          (|(tag_valid_q & ~tag_owner_q & NonTailMask));

  always_comb begin
    lock_state_d = lock_state_q;
    case (lock_state_q)
      StOpen:   if (d_lock && !p_read_pending) lock_state_d = StLocked;
      StLocked: if (!d_lock) lock_state_d = StOpen;
      default:  lock_state_d = StOpen;
    endcase
  end

  // Read-tag shift register: stage 0 takes this cycle's grant.
  always_comb begin
    tag_valid_d    = tag_valid_q << 1;
    tag_owner_d    = tag_owner_q << 1;
    tag_valid_d[0] = read_push;
    tag_owner_d[0] = grant_d;
  end

  assign tail_valid = tag_valid_q[READ_LATENCY-1];
  assign tail_owner = tag_owner_q[READ_LATENCY-1];
  assign p_rvalid   = tail_valid & ~tail_owner;
  assign d_rvalid   = tail_valid & tail_owner;
  assign p_q        = p_rvalid ? q_dmem : p_q_hold_q;
  assign d_q        = d_rvalid ? q_dmem : d_q_hold_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_state_q    <= StOpen;
      last_winner_d_q <= 1'b1;
      tag_valid_q     <= '0;
      tag_owner_q     <= '0;
      p_q_hold_q      <= '0;
      d_q_hold_q      <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      tag_valid_q  <= tag_valid_d;
      tag_owner_q  <= tag_owner_d;
      if (grant_p || grant_d) last_winner_d_q <= grant_d;
      if (p_rvalid) p_q_hold_q <= q_dmem;
      if (d_rvalid) d_q_hold_q <= q_dmem;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two instances (read latency 1 and 3) share the
// same request stimulus, each with its own dmem model, and are compared every
// cycle against a queue-based reference model plus a vector table and a few
// hand-written sequences.
module tb_dmem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p_req, p_wren, d_req, d_wren, d_lock;
  logic [11:0] p_address, d_address;
  logic [31:0] p_data, d_data;

  logic [1:0]  p_gnt_v, p_rvalid_v, d_gnt_v, d_rvalid_v, locked_v, wren_v;
  logic [31:0] p_q_v [2];
  logic [31:0] d_q_v [2];
  logic [31:0] data_v [2];
  logic [11:0] addr_v [2];
  logic [31:0] q1, rd3_0, rd3_1, q3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  dmem_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .READ_LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_wren(p_wren), .p_address(p_address), .p_data(p_data),
    .p_gnt(p_gnt_v[0]), .p_rvalid(p_rvalid_v[0]), .p_q(p_q_v[0]),
    .d_req(d_req), .d_wren(d_wren), .d_address(d_address), .d_data(d_data),
    .d_lock(d_lock), .d_gnt(d_gnt_v[0]), .d_rvalid(d_rvalid_v[0]), .d_q(d_q_v[0]),
    .locked(locked_v[0]), .address_dmem(addr_v[0]), .data(data_v[0]),
    .wren(wren_v[0]), .q_dmem(q1)
  );

  dmem_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .READ_LATENCY(3)) u_dut3 (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_wren(p_wren), .p_address(p_address), .p_data(p_data),
    .p_gnt(p_gnt_v[1]), .p_rvalid(p_rvalid_v[1]), .p_q(p_q_v[1]),
    .d_req(d_req), .d_wren(d_wren), .d_address(d_address), .d_data(d_data),
    .d_lock(d_lock), .d_gnt(d_gnt_v[1]), .d_rvalid(d_rvalid_v[1]), .d_q(d_q_v[1]),
    .locked(locked_v[1]), .address_dmem(addr_v[1]), .data(data_v[1]),
    .wren(wren_v[1]), .q_dmem(q3)
  );

  function automatic logic [31:0] init_word(input logic [11:0] a);
    return (a == 12'h005) ? 32'h0000ABCD : (32'h1000_0000 + {20'h0, a});
  endfunction

  // dmem models: unwritten words read back their initial pattern.
  logic [31:0] mem1 [int];
  logic [31:0] mem3 [int];

  always @(posedge clock) begin
    q1 <= mem1.exists(int'(addr_v[0])) ? mem1[int'(addr_v[0])] : init_word(addr_v[0]);
    if (wren_v[0]) mem1[int'(addr_v[0])] = data_v[0];
  end

  always @(posedge clock) begin
    rd3_0 <= mem3.exists(int'(addr_v[1])) ? mem3[int'(addr_v[1])] : init_word(addr_v[1]);
    rd3_1 <= rd3_0;
    q3    <= rd3_1;
    if (wren_v[1]) mem3[int'(addr_v[1])] = data_v[1];
  end

  // Reference model: expected read returns are a queue of due cycles.
  typedef struct {
    int          k;
    int          due;
    bit          owner;  // 1: D
    logic [31:0] d;
  } ret_t;

  ret_t        rq[$];
  bit          m_lw [2];      // 1: D won last
  bit          m_locked [2];
  logic [31:0] m_pq [2];
  logic [31:0] m_dq [2];
  logic [31:0] ref1 [int];
  logic [31:0] ref3 [int];

  function automatic logic [31:0] ref_rd(input int k, input logic [11:0] a);
    if (k == 0) return ref1.exists(int'(a)) ? ref1[int'(a)] : init_word(a);
    return ref3.exists(int'(a)) ? ref3[int'(a)] : init_word(a);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    for (int k = 0; k < 2; k++) begin
      m_lw[k] = 1'b1;
      m_locked[k] = 1'b0;
      m_pq[k] = '0;
      m_dq[k] = '0;
    end
  endtask

  task automatic model_cycle(input int k, input int lat);
    bit pg, dg, ew, pv, dv, p_infl;
    logic [11:0] ea;
    logic [31:0] ed;
    ret_t keep[$];
    pg = 0; dg = 0;
    if (m_locked[k]) dg = d_req;
    else if (p_req && d_req) begin
      if (m_lw[k]) pg = 1; else dg = 1;
    end else begin
      pg = p_req; dg = d_req;
    end
    ea = pg ? p_address : (dg ? d_address : 12'h0);
    ed = pg ? p_data : (dg ? d_data : 32'h0);
    ew = pg ? p_wren : (dg ? d_wren : 1'b0);
    pv = 0; dv = 0;
    p_infl = pg && !p_wren;
    foreach (rq[i]) begin
      if (rq[i].k != k) keep.push_back(rq[i]);
      else if (rq[i].due == cyc) begin
        if (rq[i].owner) begin dv = 1; m_dq[k] = rq[i].d; end
        else begin pv = 1; m_pq[k] = rq[i].d; end
      end else begin
        keep.push_back(rq[i]);
        if (!rq[i].owner) p_infl = 1;
      end
    end
    rq = keep;
    chk("p_gnt", k, {31'h0, p_gnt_v[k]}, {31'h0, pg});
    chk("d_gnt", k, {31'h0, d_gnt_v[k]}, {31'h0, dg});
    chk("wren", k, {31'h0, wren_v[k]}, {31'h0, ew});
    chk("address_dmem", k, {20'h0, addr_v[k]}, {20'h0, ea});
    chk("data", k, data_v[k], ed);
    chk("p_rvalid", k, {31'h0, p_rvalid_v[k]}, {31'h0, pv});
    chk("d_rvalid", k, {31'h0, d_rvalid_v[k]}, {31'h0, dv});
    chk("p_q", k, p_q_v[k], m_pq[k]);
    chk("d_q", k, d_q_v[k], m_dq[k]);
    chk("locked", k, {31'h0, locked_v[k]}, {31'h0, m_locked[k]});
    if (pg || dg) m_lw[k] = dg;
    if ((pg || dg) && !ew) rq.push_back('{k: k, due: cyc + lat, owner: dg, d: ref_rd(k, ea)});
    if ((pg || dg) && ew) begin
      if (k == 0) ref1[int'(ea)] = ed; else ref3[int'(ea)] = ed;
    end
    if (m_locked[k]) begin
      if (!d_lock) m_locked[k] = 0;
    end else if (d_lock && !p_infl) m_locked[k] = 1;
  endtask

  task automatic step(input bit pr, input bit pw, input logic [11:0] pa, input logic [31:0] pd,
                      input bit dr, input bit dw, input logic [11:0] da, input logic [31:0] dd,
                      input bit dl);
    @(negedge clock);
    p_req = pr; p_wren = pw; p_address = pa; p_data = pd;
    d_req = dr; d_wren = dw; d_address = da; d_data = dd; d_lock = dl;
    #1;
    model_cycle(0, 1);
    model_cycle(1, 3);
    cyc++;
  endtask

  task automatic idle_inputs();
    p_req = 0; p_wren = 0; p_address = '0; p_data = '0;
    d_req = 0; d_wren = 0; d_address = '0; d_data = '0; d_lock = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    bit rb;
    bit pr, pw; logic [11:0] pa; logic [31:0] pd;
    bit dr, dw; logic [11:0] da; logic [31:0] dd; bit dl;
    bit pg, dg, wr; logic [11:0] ad; logic [31:0] dt;
    bit pv; logic [31:0] pq; bit dv; logic [31:0] dq; bit lk;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mkv(bit rb, bit pr, bit pw, logic [11:0] pa, logic [31:0] pd,
                               bit dr, bit dw, logic [11:0] da, logic [31:0] dd, bit dl,
                               bit pg, bit dg, bit wr, logic [11:0] ad, logic [31:0] dt,
                               bit pv, logic [31:0] pq, bit dv, logic [31:0] dq, bit lk);
    vec_t v;
    v.rb = rb; v.pr = pr; v.pw = pw; v.pa = pa; v.pd = pd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.dl = dl;
    v.pg = pg; v.dg = dg; v.wr = wr; v.ad = ad; v.dt = dt;
    v.pv = pv; v.pq = pq; v.dv = dv; v.dq = dq; v.lk = lk;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dl;
    idle_inputs();
    model_reset();
    // Latency-1 instance, expectations worked out by hand.
    tbl[0] = mkv(1, 1,0,12'h005,0, 0,0,0,0, 0,  1,0,0,12'h005,0, 0,32'h0,         0,32'h0,         0);
    tbl[1] = mkv(0, 0,0,0,0,       0,0,0,0, 0,  0,0,0,0,0,       1,32'h0000ABCD,  0,32'h0,         0);
    tbl[2] = mkv(1, 1,0,12'h010,0, 1,0,12'h020,0, 0, 1,0,0,12'h010,0, 0,32'h0,    0,32'h0,         0);
    tbl[3] = mkv(0, 1,0,12'h011,0, 1,0,12'h020,0, 0, 0,1,0,12'h020,0, 1,32'h10000010, 0,32'h0,     0);
    tbl[4] = mkv(0, 1,0,12'h011,0, 1,0,12'h021,0, 0, 1,0,0,12'h011,0,
                 0,32'h10000010, 1,32'h10000020, 0);
    tbl[5] = mkv(0, 1,0,12'h012,0, 1,0,12'h021,0, 0, 0,1,0,12'h021,0,
                 1,32'h10000011, 0,32'h10000020, 0);
    tbl[6] = mkv(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0, 0,32'h10000011, 1,32'h10000021, 0);
    tbl[7] = mkv(0, 0,0,0,0, 1,1,12'h123,32'hDEADBEEF, 0, 0,1,1,12'h123,32'hDEADBEEF,
                 0,32'h10000011, 0,32'h10000021, 0);
    tbl[8] = mkv(0, 1,0,12'h123,0, 0,0,0,0, 0, 1,0,0,12'h123,0,
                 0,32'h10000011, 0,32'h10000021, 0);
    tbl[9] = mkv(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0, 1,32'hDEADBEEF, 0,32'h10000021, 0);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rb) do_reset();
      step(tbl[i].pr, tbl[i].pw, tbl[i].pa, tbl[i].pd,
           tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd, tbl[i].dl);
      chk($sformatf("tbl%0d_p_gnt", i), 0, {31'h0, p_gnt_v[0]}, {31'h0, tbl[i].pg});
      chk($sformatf("tbl%0d_d_gnt", i), 0, {31'h0, d_gnt_v[0]}, {31'h0, tbl[i].dg});
      chk($sformatf("tbl%0d_wren", i), 0, {31'h0, wren_v[0]}, {31'h0, tbl[i].wr});
      chk($sformatf("tbl%0d_addr", i), 0, {20'h0, addr_v[0]}, {20'h0, tbl[i].ad});
      chk($sformatf("tbl%0d_data", i), 0, data_v[0], tbl[i].dt);
      chk($sformatf("tbl%0d_p_rvalid", i), 0, {31'h0, p_rvalid_v[0]}, {31'h0, tbl[i].pv});
      chk($sformatf("tbl%0d_p_q", i), 0, p_q_v[0], tbl[i].pq);
      chk($sformatf("tbl%0d_d_rvalid", i), 0, {31'h0, d_rvalid_v[0]}, {31'h0, tbl[i].dv});
      chk($sformatf("tbl%0d_d_q", i), 0, d_q_v[0], tbl[i].dq);
      chk($sformatf("tbl%0d_locked", i), 0, {31'h0, locked_v[0]}, {31'h0, tbl[i].lk});
    end

    // Lock waits for the in-flight P read, then shuts P out until d_lock drops.
    do_reset();
    step(1,0,12'h030,0, 0,0,0,0, 1);
    chk("lock_s0_locked", 0, {31'h0, locked_v[0]}, 32'd0);
    chk("lock_s0_p_gnt", 0, {31'h0, p_gnt_v[0]}, 32'd1);
    step(0,0,0,0, 0,0,0,0, 1);
    chk("lock_s1_locked", 0, {31'h0, locked_v[0]}, 32'd0);
    chk("lock_s1_p_rvalid", 0, {31'h0, p_rvalid_v[0]}, 32'd1);
    step(1,0,12'h031,0, 1,0,12'h040,0, 1);
    chk("lock_s2_locked", 0, {31'h0, locked_v[0]}, 32'd1);
    chk("lock_s2_p_gnt", 0, {31'h0, p_gnt_v[0]}, 32'd0);
    chk("lock_s2_d_gnt", 0, {31'h0, d_gnt_v[0]}, 32'd1);
    step(1,0,12'h031,0, 1,1,12'h041,32'h55, 1);
    chk("lock_s3_p_gnt", 0, {31'h0, p_gnt_v[0]}, 32'd0);
    chk("lock_s3_wren", 0, {31'h0, wren_v[0]}, 32'd1);
    step(1,0,12'h031,0, 0,0,0,0, 0);
    chk("lock_s4_p_gnt", 0, {31'h0, p_gnt_v[0]}, 32'd0);
    chk("lock_s4_locked", 0, {31'h0, locked_v[0]}, 32'd1);
    step(1,0,12'h031,0, 0,0,0,0, 0);
    chk("lock_s5_p_gnt", 0, {31'h0, p_gnt_v[0]}, 32'd1);
    chk("lock_s5_locked", 0, {31'h0, locked_v[0]}, 32'd0);
    step(0,0,0,0, 0,0,0,0, 0);

    // Reset lands while a P read is in flight on both instances.
    do_reset();
    step(1,0,12'h070,0, 0,0,0,0, 0);
    chk("rst_p_gnt", 0, {31'h0, p_gnt_v[0]}, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(0,0,0,0, 0,0,0,0, 0);
      chk("rst_no_p_rvalid_l1", 0, {31'h0, p_rvalid_v[0]}, 32'd0);
      chk("rst_no_p_rvalid_l3", 1, {31'h0, p_rvalid_v[1]}, 32'd0);
    end
    step(1,0,12'h071,0, 1,0,12'h072,0, 0);
    chk("rst_first_conflict_p", 0, {31'h0, p_gnt_v[0]}, 32'd1);
    chk("rst_first_conflict_d", 0, {31'h0, d_gnt_v[0]}, 32'd0);

    // Latency 3: P, D, P back-to-back.
    do_reset();
    step(1,0,12'h050,0, 0,0,0,0, 0);
    step(0,0,0,0, 1,0,12'h060,0, 0);
    step(1,0,12'h051,0, 0,0,0,0, 0);
    chk("l3_s2_p_rvalid", 1, {31'h0, p_rvalid_v[1]}, 32'd0);
    step(0,0,0,0, 0,0,0,0, 0);
    chk("l3_s3_p_rvalid", 1, {31'h0, p_rvalid_v[1]}, 32'd1);
    chk("l3_s3_p_q", 1, p_q_v[1], 32'h10000050);
    step(0,0,0,0, 0,0,0,0, 0);
    chk("l3_s4_d_rvalid", 1, {31'h0, d_rvalid_v[1]}, 32'd1);
    chk("l3_s4_p_rvalid", 1, {31'h0, p_rvalid_v[1]}, 32'd0);
    chk("l3_s4_d_q", 1, d_q_v[1], 32'h10000060);
    step(0,0,0,0, 0,0,0,0, 0);
    chk("l3_s5_p_rvalid", 1, {31'h0, p_rvalid_v[1]}, 32'd1);
    chk("l3_s5_p_q", 1, p_q_v[1], 32'h10000051);

    // Random traffic on a small address window, occasional lock and reset.
    dl = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 19) == 0) dl = ~dl;
      step(($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
           12'($urandom_range(0, 15)), $urandom(),
           ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
           12'($urandom_range(0, 15)), $urandom(), dl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single synchronous dmem port between two requesters: the processor (port P) and a debug/program-loader master (port D).
- Grants at most one access per clock and drives the dmem address/data/wren.
- Tracks in-flight reads through the fixed dmem read latency and returns read data with a valid strobe to the requester that issued the read.
- Sits between the processor/loader and the dmem instance in the top-level wrapper.

Parameters:
- ADDR_WIDTH, 12, dmem address width.
- DATA_WIDTH, 32, dmem word width.
- READ_LATENCY, 1, clock cycles from granted read to q_dmem valid; legal range 1..4.

Ports:
- clock  in  1  single clock for arbiter and dmem.
- reset  in  1  asynchronous, active-high.
- p_req  in  1  processor access request; held until p_gnt.
- p_wren  in  1  processor write (1) / read (0).
- p_address  in  ADDR_WIDTH  processor word address.
- p_data  in  DATA_WIDTH  processor write data.
- p_gnt  out  1  processor access accepted this cycle.
- p_rvalid  out  1  p_q holds read data for an earlier granted P read.
- p_q  out  DATA_WIDTH  read data to processor.
- d_req  in  1  debug access request; held until d_gnt.
- d_wren  in  1  debug write/read.
- d_address  in  ADDR_WIDTH  debug word address.
- d_data  in  DATA_WIDTH  debug write data.
- d_lock  in  1  debug requests exclusive ownership of dmem.
- d_gnt  out  1  debug access accepted this cycle.
- d_rvalid  out  1  d_q valid.
- d_q  out  DATA_WIDTH  read data to debug.
- locked  out  1  debug currently owns dmem exclusively.
- address_dmem  out  ADDR_WIDTH  to dmem.
- data  out  DATA_WIDTH  to dmem.
- wren  out  1  to dmem.
- q_dmem  in  DATA_WIDTH  from dmem.

Behaviour:
- Reset (async): last_winner=D, so P wins the first conflict. Lock state cleared. Read-tag pipeline flushed. All outputs 0.
- Grant is combinational in the request cycle:
  - p_gnt/d_gnt, address_dmem, data and wren reflect the winner's inputs in the same cycle.
  - With no grant: wren=0, address_dmem=0, data=0.
- Arbitration, unlocked:
  - Only one requester → it wins.
  - Both request → the one that is not last_winner wins.
  - last_winner updates at the clock edge on every grant.
- Lock state machine with states OPEN and LOCKED:
  - OPEN→LOCKED at a clock edge when d_lock=1 and no P read is in flight.
  - LOCKED→OPEN at the clock edge where d_lock=0.
  - In LOCKED: p_gnt=0 always; D is granted whenever d_req=1; locked=1.
  - While d_lock=1 in OPEN: P is still granted (normal round-robin) until the transition.
- Read return:
  - Each granted read pushes {valid=1, owner} into a READ_LATENCY-deep shift register; writes and idle cycles push valid=0.
  - At the pipeline tail, q_dmem is routed to the owner's *_q with *_rvalid=1 for exactly one cycle.
  - The other port's *_q holds its last value and its rvalid=0.
- Throughput: one grant per cycle, back-to-back reads allowed. Reads to the two owners may interleave, and each owner's returns stay in its own issue order.
- Write then read of the same address in consecutive cycles returns the new data (dmem semantics). The arbiter inserts no bubble.
- Reset asserted mid-transfer: in-flight reads are discarded and no rvalid appears after reset deasserts.
- p_req/d_req dropped without a grant: legal, no side effects.

Test Plan:
- P alone: reset, P read addr 0x005 (dmem[5]=0x0000ABCD), READ_LATENCY=1 → p_gnt same cycle; next cycle p_rvalid=1, p_q=0x0000ABCD; d_rvalid stays 0.
- Conflict: P and D both request reads every cycle for 4 cycles from reset → grants in order P,D,P,D; rvalids return alternately P,D,P,D with the correct words.
- Write/read: D write 0x123 ← 0xDEADBEEF, then P read 0x123 next cycle → wren=1 for one cycle; p_q=0xDEADBEEF one cycle later.
- Lock: P read in flight, d_lock raised → locked=0 until the P read returns, then locked=1. P then requests for 3 cycles → p_gnt=0 throughout while D reads/writes proceed. After d_lock drops, P is granted the next cycle.
- Reset mid-read: P read granted, reset pulsed before the return cycle → no p_rvalid ever. After reset all outputs are 0, and a conflicting first request goes to P.
- READ_LATENCY=3: P, D, P back-to-back reads → rvalids appear 3 cycles after each grant, routed P, D, P with matching data.
